// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding, default widths and watchdog sizing for the APB bridge
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  function automatic int wd_width(input int t);
    return t > 0 ? $clog2(t + 1) : 1;
  endfunction
endpackage

// File: rtl/apb_watchdog.sv
// apb_watchdog: saturating ACCESS-cycle counter that flags the last cycle before the limit
module apb_watchdog #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != {W{1'b1}}) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
  // fires on the stalled cycle that brings the count up to the limit; limit 0 disables
  assign expired_o = en_i && limit_i != '0 && cnt_q >= limit_i - W'(1);
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB initiator with ACCESS watchdog
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              p_clk_i,
  input  logic              p_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic [ADDR_W-1:0] p_adr_o,
  output logic [DATA_W-1:0] p_dat_o,
  input  logic [DATA_W-1:0] p_dat_i,
  output logic              p_sel_o,
  output logic              p_enable_o,
  output logic              p_we_o,
  input  logic              p_ready_i,
  input  logic              p_slverr_i
);
  localparam int CW = wd_width(TIMEOUT);
  apb_state_t        state_q;
  logic              cmd_ready_q, rsp_valid_q, rsp_err_q, rsp_tout_q;
  logic              sel_q, enable_q, we_q;
  logic [DATA_W-1:0] rdata_q, dat_q;
  logic [ADDR_W-1:0] adr_q;
  logic              accept, expired;
  assign accept = state_q == IDLE && cmd_valid_i && cmd_ready_q;
  apb_watchdog #(.W(CW)) u_wd (
    .clk_i    (p_clk_i),
    .rst_i    (p_rst_i),
    .clr_i    (accept),
    .en_i     (state_q == ACCESS && !p_ready_i),
    .limit_i  (CW'(TIMEOUT)),
    .expired_o(expired)
  );
  always_ff @(posedge p_clk_i) begin
    if (p_rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tout_q  <= 1'b0;
      rdata_q     <= '0;
      sel_q       <= 1'b0;
      enable_q    <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= !accept;
          if (accept) begin
            state_q <= SETUP;
            sel_q   <= 1'b1;
            we_q    <= cmd_we_i;
            adr_q   <= cmd_addr_i;
            dat_q   <= cmd_we_i ? cmd_wdata_i : '0;
          end
        end
        SETUP: begin
          state_q  <= ACCESS;
          enable_q <= 1'b1;
        end
        ACCESS: begin
          // a ready slave beats the watchdog when both land on the same cycle
          if (p_ready_i || expired) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= (p_ready_i && !we_q) ? p_dat_i : '0;
            rsp_err_q   <= p_ready_i ? p_slverr_i : 1'b1;
            rsp_tout_q  <= !p_ready_i;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tout_q  <= 1'b0;
            rdata_q     <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_tout_q;
  assign p_adr_o       = adr_q;
  assign p_dat_o       = dat_q;
  assign p_sel_o       = sel_q;
  assign p_enable_o    = enable_q;
  assign p_we_o        = we_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed and randomized APB transfers against a transaction-level model
module tb_apb_master_bridge;
  localparam int TMO = 8;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, p_dat = '0;
  logic        p_ready = 1'b0, p_slverr = 1'b0;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, p_sel_o, p_enable_o, p_we_o;
  logic [31:0] rsp_rdata_o, p_adr_o, p_dat_o;
  int          checks = 0, failures = 0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .p_clk_i(clk), .p_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .p_adr_o(p_adr_o), .p_dat_o(p_dat_o), .p_dat_i(p_dat),
    .p_sel_o(p_sel_o), .p_enable_o(p_enable_o), .p_we_o(p_we_o),
    .p_ready_i(p_ready), .p_slverr_i(p_slverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave inserts `waits` not-ready ACCESS cycles; the model predicts how the transfer ends.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic serr, input logic [31:0] rd,
                      input int rdly, input logic hold_cmd);
    int n, ncyc;
    logic tout, eerr;
    logic [31:0] erd;
    tout = waits >= TMO;
    ncyc = tout ? TMO : waits + 1;
    erd  = (tout || we) ? 32'h0 : rd;
    eerr = tout || serr;
    n = 0;
    while (!cmd_ready_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    chk("setup_ctl", {p_sel_o, p_enable_o, cmd_ready_o, rsp_valid_o}, 4'b1000);
    chk("setup_adr", p_adr_o, addr);
    chk("setup_dat", {p_we_o, p_dat_o}, {we, we ? wdata : 32'h0});
    p_ready = 1'($urandom); p_slverr = 1'b1; p_dat = $urandom;
    @(negedge clk);
    for (int i = 0; i < ncyc; i++) begin
      chk("access_ctl", {p_sel_o, p_enable_o, rsp_valid_o}, 3'b110);
      chk("access_bus", {p_we_o, p_adr_o, p_dat_o}, {we, addr, we ? wdata : 32'h0});
      p_ready  = (i == waits);
      p_slverr = (i == waits) ? serr : 1'($urandom);
      p_dat    = (i == waits) ? rd : $urandom;
      @(negedge clk);
    end
    p_ready = 1'b0; p_slverr = 1'($urandom); p_dat = $urandom;
    chk("rsp_valid", rsp_valid_o, 1);
    chk("rsp_data", {rsp_rdata_o, rsp_err_o, rsp_timeout_o}, {erd, eerr, tout});
    chk("rsp_bus_idle", {p_sel_o, p_enable_o, p_we_o, p_adr_o, p_dat_o, cmd_ready_o}, 0);
    for (int j = 0; j < rdly; j++) begin
      cmd_valid = hold_cmd;
      @(negedge clk);
      chk("rsp_hold", {rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o}, {1'b1, erd, eerr, tout});
      chk("rsp_hold_busy", {cmd_ready_o, p_sel_o}, 0);
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp", {rsp_valid_o, cmd_ready_o, p_sel_o}, 3'b010);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, p_sel_o,
        p_enable_o, p_we_o, |rsp_rdata_o, |p_adr_o, |p_dat_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {cmd_ready_o, rsp_valid_o}, 2'b10);
    xfer(1'b1, 32'h0, 32'hA5, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    xfer(1'b0, 32'h4, 32'h1234, 3, 1'b0, 32'hC7, 0, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 30, 1'b0, 32'h5555, 0, 1'b0);
    xfer(1'b0, 32'h14, 32'h0, TMO, 1'b0, 32'h6666, 0, 1'b0);
    xfer(1'b0, 32'h18, 32'h0, TMO - 1, 1'b0, 32'h7777, 0, 1'b0);
    xfer(1'b0, 32'h8, 32'h0, 1, 1'b1, 32'h5A5A_0001, 0, 1'b0);
    xfer(1'b1, 32'hC, 32'h99, 0, 1'b0, 32'h0, 5, 1'b1);
    xfer(1'b1, 32'h20, 32'h77, 2, 1'b1, 32'h0, 1, 1'b0);
    n_rand();
    // abort a transfer with reset in the middle of ACCESS
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h40;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_access", {p_sel_o, p_enable_o}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", {cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, p_sel_o,
        p_enable_o, p_we_o, |rsp_rdata_o, |p_adr_o, |p_dat_o}, 0);
    rst = 1'b0; p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
    chk("after_reset_idle", {cmd_ready_o, rsp_valid_o, p_sel_o}, 3'b100);
    repeat (3) @(negedge clk);
    chk("no_rsp_after_reset", {rsp_valid_o, p_sel_o}, 0);
    xfer(1'b0, 32'h44, 32'h0, 0, 1'b0, 32'h1357_9BDF, 0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic n_rand();
    for (int k = 0; k < 40; k++)
      xfer(1'($urandom), $urandom, $urandom, $urandom_range(0, TMO + 3), 1'($urandom),
           $urandom, $urandom_range(0, 3), 1'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "simulation did not finish");
  end
endmodule
